// File: rtl/tpg_video_param.sv
`default_nettype none
// ============================================================================
// Module      : tpg_video_param
// Description : Wishbone-master test-pattern generator. Writes full frames of
//               HDISP x VDISP pixels into frame memory with incrementing
//               bursts; selectable pattern, per-frame animation, short final
//               burst and sticky error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_video_param #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter int unsigned BASE_ADDR = 0,
    parameter int          BURST_LEN = 16,
    parameter int          ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    output logic              cyc,
    output logic              stb,
    output logic              we,
    output logic [ADDR_W-1:0] adr,
    output logic [31:0]       dat_ms,
    output logic [3:0]        sel,
    output logic [2:0]        cti,
    output logic [1:0]        bte,
    input  logic              ack,
    input  logic              err,
    output logic              frame_done,
    output logic              err_flag,
    output logic [15:0]       frame_cnt
);

    localparam int                c_XW     = $clog2(HDISP);
    localparam int                c_YW     = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int                c_BW     = $clog2(BURST_LEN + 1);
    localparam logic [31:0]       c_HDISP  = 32'(HDISP);
    localparam logic [31:0]       c_NPIX   = 32'(HDISP) * 32'(VDISP);
    localparam logic [31:0]       c_BLEN   = 32'(BURST_LEN);
    localparam logic [c_BW-1:0]   c_FIRST  = (c_NPIX < c_BLEN) ? c_BW'(c_NPIX) : c_BW'(BURST_LEN);
    localparam logic [c_BW-1:0]   c_ONE    = c_BW'(1);
    localparam logic [c_BW-1:0]   c_TWO    = c_BW'(2);
    localparam logic [c_XW-1:0]   c_XMAX   = c_XW'(HDISP - 1);
    localparam logic [ADDR_W-1:0] c_BASE   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_STEP   = ADDR_W'(4);
    localparam logic [2:0]        c_CTI_INC = 3'b010;
    localparam logic [2:0]        c_CTI_END = 3'b111;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]      r_state;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [1:0]      r_mode;
    logic [31:0]     r_frame_rem;   // beats still to terminate in this frame
    logic [c_BW-1:0] r_burst_rem;   // beats still to terminate in this burst

    logic            w_last_x;
    logic [c_XW-1:0] w_x_nxt;
    logic [c_YW-1:0] w_y_nxt;
    logic            w_term;
    logic [c_BW-1:0] w_gap_len;
    logic [31:0]     w_dat_nxt;
    logic [31:0]     w_dat_first;

    // Pixel value for one position; pf is the low byte of the frame counter.
    function automatic logic [31:0] f_pixel(input logic [31:0] px, input logic [31:0] py,
                                            input logic [1:0] pm, input logic [7:0] pf);
        logic [31:0] bar;
        logic [7:0]  grey;
        logic        tile;
        bar  = (px << 3) / c_HDISP;
        grey = px[7:0] + pf;
        tile = px[4] ^ py[4] ^ pf[0];
        case (pm)
            2'd0: begin
                case (bar)
                    32'd0:   f_pixel = 32'h00FFFFFF;
                    32'd1:   f_pixel = 32'h00FFFF00;
                    32'd2:   f_pixel = 32'h0000FFFF;
                    32'd3:   f_pixel = 32'h0000FF00;
                    32'd4:   f_pixel = 32'h00FF00FF;
                    32'd5:   f_pixel = 32'h00FF0000;
                    32'd6:   f_pixel = 32'h000000FF;
                    default: f_pixel = 32'h00000000;
                endcase
            end
            2'd1:    f_pixel = {8'h00, grey, grey, grey};
            2'd2:    f_pixel = tile ? 32'h00FFFFFF : 32'h00000000;
            default: f_pixel = py * c_HDISP + px;
        endcase
    endfunction

    assign w_last_x    = (r_x == c_XMAX);
    assign w_x_nxt     = w_last_x ? '0 : r_x + 1'b1;
    assign w_y_nxt     = w_last_x ? r_y + 1'b1 : r_y;
    assign w_term      = ack | err;
    // In GAP, r_frame_rem already counts only the beats of the remaining bursts.
    assign w_gap_len   = (r_frame_rem < c_BLEN) ? c_BW'(r_frame_rem) : c_BW'(BURST_LEN);
    assign w_dat_nxt   = f_pixel(32'(w_x_nxt), 32'(w_y_nxt), r_mode, frame_cnt[7:0]);
    assign w_dat_first = f_pixel(32'd0, 32'd0, mode, frame_cnt[7:0]);

    assign sel = 4'hF;
    assign bte = 2'b00;

    // Frame/burst sequencing with all bus outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_mode      <= 2'd0;
            r_frame_rem <= 32'd0;
            r_burst_rem <= '0;
            cyc         <= 1'b0;
            stb         <= 1'b0;
            we          <= 1'b0;
            adr         <= c_BASE;
            dat_ms      <= 32'd0;
            cti         <= 3'b000;
            frame_done  <= 1'b0;
            err_flag    <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_state     <= S_BURST;
                        r_mode      <= mode;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_frame_rem <= c_NPIX;
                        r_burst_rem <= c_FIRST;
                        cyc         <= 1'b1;
                        stb         <= 1'b1;
                        we          <= 1'b1;
                        adr         <= c_BASE;
                        dat_ms      <= w_dat_first;
                        cti         <= (c_FIRST == c_ONE) ? c_CTI_END : c_CTI_INC;
                    end
                end
                S_BURST: begin
                    if (w_term) begin
                        if (err) begin
                            err_flag <= 1'b1;
                        end
                        r_frame_rem <= r_frame_rem - 32'd1;
                        if (r_frame_rem == 32'd1) begin
                            r_state    <= S_IDLE;
                            cyc        <= 1'b0;
                            stb        <= 1'b0;
                            we         <= 1'b0;
                            cti        <= 3'b000;
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 16'd1;
                        end else begin
                            r_x    <= w_x_nxt;
                            r_y    <= w_y_nxt;
                            adr    <= adr + c_STEP;
                            dat_ms <= w_dat_nxt;
                            if (r_burst_rem == c_ONE) begin
                                r_state <= S_GAP;
                                cyc     <= 1'b0;
                                stb     <= 1'b0;
                                we      <= 1'b0;
                                cti     <= 3'b000;
                            end else begin
                                r_burst_rem <= r_burst_rem - c_ONE;
                                cti         <= (r_burst_rem == c_TWO) ? c_CTI_END : c_CTI_INC;
                            end
                        end
                    end
                end
                S_GAP: begin
                    r_state     <= S_BURST;
                    r_burst_rem <= w_gap_len;
                    cyc         <= 1'b1;
                    stb         <= 1'b1;
                    we          <= 1'b1;
                    cti         <= (w_gap_len == c_ONE) ? c_CTI_END : c_CTI_INC;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tpg_video_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpg_video_param
// Description : Self-checking bench for tpg_video_param (16x4 frame, bursts
//               of 6 so the last burst of each frame is a short one of 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpg_video_param;

    localparam int          HD   = 16;
    localparam int          VD   = 4;
    localparam int          BL   = 6;
    localparam int          NPIX = HD * VD;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] BAR_TAB [8] = '{32'h00FFFFFF, 32'h00FFFF00, 32'h0000FFFF, 32'h0000FF00,
                                            32'h00FF00FF, 32'h00FF0000, 32'h000000FF, 32'h00000000};

    logic        clk = 1'b0;
    logic        rst, enable, ack, err;
    logic [1:0]  mode;
    logic        cyc, stb, we, frame_done, err_flag;
    logic [31:0] adr, dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [15:0] frame_cnt;

    int n_vec   = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    tpg_video_param #(
        .HDISP(HD), .VDISP(VD), .BASE_ADDR(0), .BURST_LEN(BL), .ADDR_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .mode(mode),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .dat_ms(dat_ms),
        .sel(sel), .cti(cti), .bte(bte), .ack(ack), .err(err),
        .frame_done(frame_done), .err_flag(err_flag), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference pixel computed straight from the pattern definitions.
    function automatic logic [31:0] ref_pix(input int x, input int y, input logic [1:0] m, input int f);
        int          v;
        logic [31:0] t;
        case (m)
            2'd0: return BAR_TAB[(x * 8) / HD];
            2'd1: begin
                v = (x + f) % 256;
                t = 32'(v);
                return {8'h00, t[7:0], t[7:0], t[7:0]};
            end
            2'd2: return ((((x / 16) + (y / 16) + f) % 2) == 1) ? 32'h00FFFFFF : 32'h00000000;
            default: return 32'(y * HD + x);
        endcase
    endfunction

    // One full frame as seen by a slave with random wait states. Entered just
    // before the edge on which the generator will start the frame.
    task automatic do_frame(input logic [1:0] m, input int maxlat, input int err_k, input int drop_k);
        int f;
        f    = exp_cnt % 256;
        mode = m;
        for (int k = 0; k < NPIX; k++) begin
            int          lat;
            bit          last_b;
            logic [31:0] e_adr, e_dat;
            logic [2:0]  e_cti;
            last_b = ((k % BL) == BL - 1) || (k == NPIX - 1);
            e_cti  = last_b ? 3'b111 : 3'b010;
            e_adr  = BASE + 32'(4 * k);
            e_dat  = ref_pix(k % HD, k / HD, m, f);
            @(negedge clk);
            if (k == NPIX / 2) mode = ~m;
            if (k == drop_k)   enable = 1'b0;
            check("cyc", 32'(cyc), 1);
            check("stb", 32'(stb), 1);
            check("we", 32'(we), 1);
            check("adr", adr, e_adr);
            check("dat", dat_ms, e_dat);
            check("cti", 32'(cti), 32'(e_cti));
            check("sel", 32'(sel), 32'hF);
            check("bte", 32'(bte), 0);
            check("frame_done_mid", 32'(frame_done), 0);
            check("err_flag", 32'(err_flag), 32'(exp_err));
            check("frame_cnt_mid", 32'(frame_cnt), 32'(exp_cnt));
            lat = $urandom_range(maxlat, 0);
            for (int w = 0; w < lat; w++) begin
                @(negedge clk);
                check("hold_stb", 32'(stb), 1);
                check("hold_adr", adr, e_adr);
                check("hold_dat", dat_ms, e_dat);
                check("hold_cti", 32'(cti), 32'(e_cti));
            end
            if (k == err_k) begin
                err     = 1'b1;
                exp_err = 1'b1;
            end else begin
                ack = 1'b1;
            end
            @(posedge clk);
            #1;
            ack = 1'b0;
            err = 1'b0;
            if (last_b && k != NPIX - 1) begin
                @(negedge clk);
                check("gap_cyc", 32'(cyc), 0);
                check("gap_stb", 32'(stb), 0);
            end
        end
        @(negedge clk);
        check("end_cyc", 32'(cyc), 0);
        check("frame_done", 32'(frame_done), 1);
        exp_cnt = (exp_cnt + 1) % 65536;
        check("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 2'd0;
        ack    = 1'b0;
        err    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_cyc", 32'(cyc), 0);
            check("rst_stb", 32'(stb), 0);
            check("rst_we", 32'(we), 0);
            check("rst_adr", adr, BASE);
            check("rst_dat", dat_ms, 0);
            check("rst_cti", 32'(cti), 0);
            check("rst_done", 32'(frame_done), 0);
            check("rst_errf", 32'(err_flag), 0);
            check("rst_cnt", 32'(frame_cnt), 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_cyc", 32'(cyc), 0);

        do_frame(2'd0, 0, -1, -1);
        do_frame(2'd3, 12, -1, -1);
        do_frame(2'd1, 3, -1, -1);
        do_frame(2'd1, 3, -1, -1);
        do_frame(2'd2, 2, 2, -1);
        do_frame(2'($urandom_range(3, 0)), 2, -1, 20);

        // enable dropped mid-frame: generator must stay idle afterwards
        repeat (3) begin
            @(negedge clk);
            check("idle_cyc", 32'(cyc), 0);
            check("idle_done", 32'(frame_done), 0);
        end
        enable = 1'b1;
        @(negedge clk);
        check("restart_cyc", 32'(cyc), 1);
        check("restart_adr", adr, BASE);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        check("beat1_adr", adr, BASE + 32'd4);
        // reset mid-burst with ack asserted: reset wins
        rst = 1'b1;
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        @(negedge clk);
        check("mid_rst_cyc", 32'(cyc), 0);
        check("mid_rst_stb", 32'(stb), 0);
        check("mid_rst_adr", adr, BASE);
        check("mid_rst_cnt", 32'(frame_cnt), 0);
        check("mid_rst_errf", 32'(err_flag), 0);
        check("mid_rst_done", 32'(frame_done), 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("final_idle", 32'(cyc), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
